// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory path.
// Contents: access-size encodings (funct3[1:0]), the responder FSM state type
// and the largest wait-state count the responder counter can hold.
package riscv_mem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam int LATENCY_MAX = 15;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'b00,
    DMEM_WAIT = 2'b01,
    DMEM_RESP = 2'b10
  } dmem_state_e;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering for byte/half/word accesses.
// Ports:
//   size, is_unsigned, addr_lo : access description (funct3 split, addr[1:0])
//   wdata                      : right-justified store data
//   rword                      : 32-bit word currently stored at the target
//   byte_en                    : lanes a store writes
//   wdata_lane                 : store data replicated into its lanes
//   rdata_ext                  : selected load data, sign- or zero-extended
//   align_err                  : illegal size or misaligned address
module load_store_align
  import riscv_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        align_err
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    rd_byte = rword[{addr_lo, 3'b000} +: 8];
    rd_half = addr_lo[1] ? rword[31:16] : rword[15:0];
  end

  always_comb begin
    byte_en    = 4'b0000;
    wdata_lane = 32'h0;
    rdata_ext  = 32'h0;
    align_err  = 1'b0;
    case (size)
      SIZE_B: begin
        byte_en    = 4'b0001 << addr_lo;
        // Replicating into every lane lets byte_en alone pick the target.
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = is_unsigned ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      end
      SIZE_H: begin
        align_err  = addr_lo[0];
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = is_unsigned ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      end
      SIZE_W: begin
        align_err  = |addr_lo;
        byte_en    = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rword;
      end
      default: align_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with valid/ready request and response
// handshakes and LATENCY wait states between accept and response.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid / req_ready    : request handshake
//   req_we, req_addr, req_size, req_unsigned, req_wdata : request fields
//   rsp_valid / rsp_ready    : response handshake
//   rsp_rdata, rsp_err       : extended load data (0 for stores/errors), error flag
//
// state     | meaning
// DMEM_IDLE | ready for a request (req_ready=1)
// DMEM_WAIT | request latched, counting down wait states
// DMEM_RESP | access done, holding the response until rsp_ready
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CNT_INIT   = 4'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [32:0] BYTE_LIMIT = 33'(4 * DEPTH_WORDS);

  dmem_state_e state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic [31:0] lat_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic        in_idle;
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [1:0]  acc_size;
  logic        acc_unsigned;
  logic [31:0] acc_wdata;
  logic        range_err;
  logic        align_err;
  logic        acc_err;
  logic        commit;
  logic [IDX_W-1:0] word_idx;
  logic [31:0] rword;
  logic [3:0]  byte_en;
  logic [31:0] wdata_lane;
  logic [31:0] rdata_ext;

  // With LATENCY==0 the access commits on the accept edge, before the latch
  // holds anything, so the live request fields feed the datapath in IDLE.
  assign in_idle      = (state == DMEM_IDLE);
  assign acc_we       = in_idle ? req_we       : lat_we;
  assign acc_addr     = in_idle ? req_addr     : lat_addr;
  assign acc_size     = in_idle ? req_size     : lat_size;
  assign acc_unsigned = in_idle ? req_unsigned : lat_unsigned;
  assign acc_wdata    = in_idle ? req_wdata    : lat_wdata;

  assign range_err = ({1'b0, acc_addr} >= BYTE_LIMIT);
  assign acc_err   = range_err | align_err;
  assign word_idx  = acc_addr[IDX_W+1:2];
  assign rword     = range_err ? 32'h0 : mem[word_idx];

  assign commit = (LATENCY == 0) ? (in_idle & req_valid)
                                 : ((state == DMEM_WAIT) && (cnt == 4'd0));

  load_store_align u_align (
    .size        (acc_size),
    .is_unsigned (acc_unsigned),
    .addr_lo     (acc_addr[1:0]),
    .wdata       (acc_wdata),
    .rword       (rword),
    .byte_en     (byte_en),
    .wdata_lane  (wdata_lane),
    .rdata_ext   (rdata_ext),
    .align_err   (align_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= DMEM_IDLE;
      cnt          <= 4'd0;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'h0;
      rsp_err      <= 1'b0;
      lat_we       <= 1'b0;
      lat_addr     <= 32'h0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_wdata    <= 32'h0;
    end else begin
      case (state)
        DMEM_IDLE: begin
          if (req_valid) begin
            lat_we       <= req_we;
            lat_addr     <= req_addr;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_wdata    <= req_wdata;
            req_ready    <= 1'b0;
            if (LATENCY == 0) begin
              state     <= DMEM_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= acc_err;
              rsp_rdata <= (acc_err || acc_we) ? 32'h0 : rdata_ext;
            end else begin
              state <= DMEM_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        DMEM_WAIT: begin
          if (cnt == 4'd0) begin
            state     <= DMEM_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= acc_err;
            rsp_rdata <= (acc_err || acc_we) ? 32'h0 : rdata_ext;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DMEM_RESP: begin
          if (rsp_ready) begin
            state     <= DMEM_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= DMEM_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Storage is never cleared; reset only suppresses a pending commit.
  always_ff @(posedge clk) begin
    if (!rst && commit && acc_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized plus directed bench for dmem_responder. Two instances share the
// request fields: u_dut with LATENCY=2 (sel 0) and u_dut0 with LATENCY=0 (sel 1).
// Expected values come from a byte-array memory model per instance.
module tb_dmem_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;

  logic        valid_a, ready_a, rspv_a, rspr_a, err_a;
  logic [31:0] rdata_a;
  logic        valid_b, ready_b, rspv_b, rspr_b, err_b;
  logic [31:0] rdata_b;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(valid_a), .req_ready(ready_a), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(rspv_a), .rsp_ready(rspr_a), .rsp_rdata(rdata_a), .rsp_err(err_a)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(valid_b), .req_ready(ready_b), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(rspv_b), .rsp_ready(rspr_b), .rsp_rdata(rdata_b), .rsp_err(err_b)
  );

  bit [7:0] ref_a [4096];
  bit [7:0] ref_b [4096];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic get_ready(input int sel);
    return sel != 0 ? ready_b : ready_a;
  endfunction
  function automatic logic get_rspv(input int sel);
    return sel != 0 ? rspv_b : rspv_a;
  endfunction
  function automatic logic [31:0] get_rdata(input int sel);
    return sel != 0 ? rdata_b : rdata_a;
  endfunction
  function automatic logic get_err(input int sel);
    return sel != 0 ? err_b : err_a;
  endfunction

  function automatic bit model_err(input logic [31:0] addr, input logic [1:0] size);
    return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
           (size == 2'd2 && addr % 4 != 0) || (addr >= 32'd4096);
  endfunction

  function automatic logic [31:0] model_load(input int sel, input logic [31:0] addr,
                                             input logic [1:0] size, input logic uns);
    int n;
    logic [31:0] v;
    n = 1 << size;
    v = 32'h0;
    for (int i = 0; i < n; i++)
      v = v | (32'(sel != 0 ? ref_b[addr + i] : ref_a[addr + i]) << (8 * i));
    if (!uns && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic void model_store(input int sel, input logic [31:0] addr,
                                      input logic [1:0] size, input logic [31:0] wdata);
    int n;
    n = 1 << size;
    for (int i = 0; i < n; i++) begin
      if (sel != 0) ref_b[addr + i] = wdata[8 * i +: 8];
      else          ref_a[addr + i] = wdata[8 * i +: 8];
    end
  endfunction

  // Starts and ends on a falling edge; hold = extra cycles of rsp_ready=0.
  task automatic txn(input int sel, input logic we, input logic [31:0] addr,
                     input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                     input int hold, input string tag);
    bit          e_err;
    logic [31:0] e_rd;
    int          n;
    e_err = model_err(addr, size);
    e_rd  = (e_err || we) ? 32'h0 : model_load(sel, addr, size, uns);
    if (!e_err && we) model_store(sel, addr, size, wdata);

    req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
    if (sel != 0) valid_b = 1'b1; else valid_a = 1'b1;
    check({tag, ".req_ready"}, 32'(get_ready(sel)), 32'd1);
    @(negedge clk);
    valid_a = 1'b0; valid_b = 1'b0;
    // Scramble the fields: the DUT must be using its latched copy now.
    req_we = $urandom_range(0, 1); req_addr = $urandom; req_size = 2'($urandom);
    req_unsigned = $urandom_range(0, 1); req_wdata = $urandom;
    n = 1;
    while (!get_rspv(sel) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"}, 32'(n), (sel != 0) ? 32'd1 : 32'd3);
    check({tag, ".err"}, 32'(get_err(sel)), 32'(e_err));
    check({tag, ".rdata"}, get_rdata(sel), e_rd);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({tag, ".hold_valid"}, 32'(get_rspv(sel)), 32'd1);
      check({tag, ".hold_rdata"}, get_rdata(sel), e_rd);
      check({tag, ".hold_ready"}, 32'(get_ready(sel)), 32'd0);
    end
    if (sel != 0) rspr_b = 1'b1; else rspr_a = 1'b1;
    @(negedge clk);
    rspr_a = 1'b0; rspr_b = 1'b0;
    check({tag, ".post_ready"}, 32'(get_ready(sel)), 32'd1);
    check({tag, ".post_valid"}, 32'(get_rspv(sel)), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    int          sel;
    rst = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0; rspr_a = 1'b0; rspr_b = 1'b0;
    req_we = 1'b0; req_addr = 32'h0; req_size = 2'b00; req_unsigned = 1'b0; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("reset.req_ready", 32'(ready_a), 32'd1);
    check("reset.rsp_valid", 32'(rspv_a), 32'd0);
    check("reset.rdata", rdata_a, 32'h0);
    check("reset.err", 32'(err_a), 32'd0);

    for (int w = 0; w < 32; w++) begin
      txn(0, 1'b1, 32'(4 * w), 2'd2, 1'b0, $urandom, 0, "fill_a");
      txn(1, 1'b1, 32'(4 * w), 2'd2, 1'b0, $urandom, 0, "fill_b");
    end

    txn(0, 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 0, "sw_dead");
    txn(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0, "lw_dead");
    check("lw_dead.model", model_load(0, 32'h10, 2'd2, 1'b0), 32'hDEADBEEF);

    txn(0, 1'b1, 32'h10, 2'd2, 1'b0, 32'h11223344, 0, "sw_1122");
    txn(0, 1'b1, 32'h13, 2'd0, 1'b0, 32'h00000080, 0, "sb_80");
    txn(0, 1'b0, 32'h13, 2'd0, 1'b0, 32'h0, 0, "lb_80");
    txn(0, 1'b0, 32'h13, 2'd0, 1'b1, 32'h0, 0, "lbu_80");
    txn(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0, "lw_merged");
    check("lw_merged.model", model_load(0, 32'h10, 2'd2, 1'b0), 32'h80223344);

    txn(0, 1'b0, 32'h21, 2'd1, 1'b0, 32'h0, 0, "lh_misal");
    txn(0, 1'b1, 32'h4000, 2'd2, 1'b0, 32'hCAFEF00D, 0, "sw_range");
    txn(0, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 0, "lw_noalias");
    txn(0, 1'b0, 32'h8, 2'd3, 1'b0, 32'h0, 0, "size_ill");
    txn(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 5, "backpressure");

    // Reset during WAIT of a store: the commit edge sees rst, so no write.
    req_we = 1'b1; req_addr = 32'h40; req_size = 2'd2; req_unsigned = 1'b0;
    req_wdata = 32'hA5A5A5A5; valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_wait.rsp_valid", 32'(rspv_a), 32'd0);
    check("rst_wait.req_ready", 32'(ready_a), 32'd1);
    repeat (3) @(negedge clk);
    txn(0, 1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 0, "rst_wait.lw");

    txn(1, 1'b1, 32'h24, 2'd2, 1'b0, 32'h0BADC0DE, 0, "l0_sw");
    txn(1, 1'b0, 32'h24, 2'd2, 1'b0, 32'h0, 0, "l0_lw");
    txn(1, 1'b1, 32'h26, 2'd1, 1'b0, 32'h0000F123, 0, "l0_sh");
    txn(1, 1'b0, 32'h26, 2'd1, 1'b0, 32'h0, 0, "l0_lh");

    for (int t = 0; t < 120; t++) begin
      r   = $urandom_range(0, 9);
      a   = (r == 0) ? 32'h4000 + $urandom_range(0, 255) : 32'($urandom_range(0, 127));
      sel = $urandom_range(0, 1);
      txn(sel, 1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), $urandom, (t % 7 == 0) ? 2 : 0, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
